// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU operation codes and sequencer states shared by the multi-cycle controller.
package ctrl_pkg;
   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b010001;
   localparam logic [5:0] OP_SW    = 6'b010000;
   localparam logic [5:0] OP_SUBIU = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b101010;
   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OP_SLT   = 2'b11;
   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB_ALU, WB_MEM, TRAP
   } state_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: classifies the latched opcode and derives its ALU operation and operand source.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] op,
   output logic       legal,
   output logic       is_r,
   output logic       is_lw,
   output logic       is_sw,
   output logic [1:0] alu_op,
   output logic       alu_src
);
   logic is_subiu, is_slti;
   always_comb begin
      is_r     = op == OP_R;
      is_lw    = op == OP_LW;
      is_sw    = op == OP_SW;
      is_subiu = op == OP_SUBIU;
      is_slti  = op == OP_SLTI;
      legal    = is_r | is_lw | is_sw | is_subiu | is_slti;
      alu_op   = is_r ? ALU_OP_FUNCT : is_subiu ? ALU_OP_SUB : is_slti ? ALU_OP_SLT : ALU_OP_ADD;
      alu_src  = legal & ~is_r;
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer driving the datapath control lines,
// with a bounded memory handshake, retired-instruction counter and sticky trap.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [5:0]       instr_op,
   input  logic             mem_ready,
   input  logic             clear_trap,
   output logic             pc_w,
   output logic             ir_w,
   output logic             i_or_d,
   output logic             reg_dst,
   output logic             reg_w,
   output logic [1:0]       alu_op,
   output logic             alu_src,
   output logic             mem_r,
   output logic             mem_w,
   output logic             mem_to_reg,
   output logic             trap,
   output logic [CNT_W-1:0] retired
);
   localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   state_t          state, state_d;
   logic [5:0]      op_q;
   logic [WC_W-1:0] wait_cnt;
   logic            legal, is_r, is_lw, is_sw, dec_src, waiting, timeout, retire, alu_active;
   logic [1:0]      dec_alu;
   ctrl_decode u_decode (
      .op      (op_q),
      .legal   (legal),
      .is_r    (is_r),
      .is_lw   (is_lw),
      .is_sw   (is_sw),
      .alu_op  (dec_alu),
      .alu_src (dec_src)
   );
   assign waiting    = state inside {FETCH, MEM_RD, MEM_WR};
   // a ready in the final allowed cycle still completes the access
   assign timeout    = (MEM_TIMEOUT != 0) && waiting && !mem_ready && (wait_cnt == WC_W'(MEM_TIMEOUT - 1));
   assign retire     = (state == WB_ALU) || (state == WB_MEM) || (state == MEM_WR && mem_ready);
   assign alu_active = state inside {EXEC, MEM_RD, MEM_WR, WB_ALU, WB_MEM};
   always_comb begin
      state_d    = state;
      pc_w       = 1'b0;
      ir_w       = 1'b0;
      i_or_d     = 1'b0;
      reg_dst    = 1'b0;
      reg_w      = 1'b0;
      mem_r      = 1'b0;
      mem_w      = 1'b0;
      mem_to_reg = 1'b0;
      alu_op     = alu_active ? dec_alu : ALU_OP_ADD;
      alu_src    = alu_active & dec_src;
      case (state)
         IDLE:   state_d = en ? FETCH : IDLE;
         FETCH: begin
            mem_r   = 1'b1;
            ir_w    = mem_ready;
            state_d = mem_ready ? DECODE : timeout ? TRAP : FETCH;
         end
         DECODE: state_d = legal ? EXEC : TRAP;
         EXEC:   state_d = is_lw ? MEM_RD : is_sw ? MEM_WR : WB_ALU;
         MEM_RD: begin
            mem_r   = 1'b1;
            i_or_d  = 1'b1;
            state_d = mem_ready ? WB_MEM : timeout ? TRAP : MEM_RD;
         end
         MEM_WR: begin
            mem_w   = 1'b1;
            i_or_d  = 1'b1;
            pc_w    = mem_ready;
            state_d = mem_ready ? (en ? FETCH : IDLE) : timeout ? TRAP : MEM_WR;
         end
         WB_ALU: begin
            reg_w   = 1'b1;
            reg_dst = is_r;
            pc_w    = 1'b1;
            state_d = en ? FETCH : IDLE;
         end
         WB_MEM: begin
            reg_w      = 1'b1;
            mem_to_reg = 1'b1;
            pc_w       = 1'b1;
            state_d    = en ? FETCH : IDLE;
         end
         TRAP:   state_d = clear_trap ? IDLE : TRAP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         op_q     <= '0;
         wait_cnt <= '0;
         retired  <= '0;
         trap     <= 1'b0;
      end else begin
         state    <= state_d;
         if (state == FETCH && mem_ready) op_q <= instr_op;
         // any state change restarts the wait count for the next memory access
         wait_cnt <= (state_d != state) ? '0 : (waiting && !mem_ready) ? wait_cnt + 1'b1 : wait_cnt;
         if (retire) retired <= retired + 1'b1;
         trap     <= state_d == TRAP;
      end
   end
endmodule
